relu_maxpool: RTL

RELU_MAXPOOL -- requirements
Module: relu_maxpool

---
 rtl/relu_maxpool.sv | 122 ++++++++++++
 1 files changed

// File: rtl/relu_maxpool.sv
// ReLU activation followed by 2x2 stride-2 max pooling on a raster pixel stream.
// Define RELU_MAXPOOL_LEAKY_EN to turn negative samples into x >>> 3 instead of 0.
module relu_maxpool #(
  parameter int unsigned CONV_BIT = 12,
  parameter int unsigned CH       = 3,
  parameter int unsigned IMG_W    = 24,
  parameter int unsigned IMG_H    = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic                   sof,
  input  logic [CH*CONV_BIT-1:0] din,
  output logic [CH*CONV_BIT-1:0] dout,
  output logic                   valid_out,
  output logic                   frame_done
);

  localparam int unsigned DW   = CH * CONV_BIT;
  localparam int unsigned CW   = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW   = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int unsigned LB_N = IMG_W / 2;
  localparam int unsigned LBW  = (LB_N > 1) ? $clog2(LB_N) : 1;

  function automatic logic [CONV_BIT-1:0] act_f(input logic [CONV_BIT-1:0] x);
`ifdef RELU_MAXPOOL_LEAKY_EN
    act_f = x[CONV_BIT-1] ? CONV_BIT'($signed(x) >>> 3) : x;
`else
    act_f = x[CONV_BIT-1] ? '0 : x;
`endif
  endfunction

  function automatic logic [CONV_BIT-1:0] max_f(input logic [CONV_BIT-1:0] a,
                                                input logic [CONV_BIT-1:0] b);
    max_f = ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic [DW-1:0] even_q, even_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [DW-1:0] lb_q [LB_N];
  logic [DW-1:0] lb_rd, pair_v, win_v;
  logic [LBW-1:0] lb_idx;
  logic          lb_we;

  // A sof beat is position (0,0) regardless of where the counters stood.
  always_comb begin
    col_eff = sof ? '0 : col_q;
    row_eff = sof ? '0 : row_q;
    lb_idx  = LBW'(col_eff >> 1);
    lb_rd   = lb_q[lb_idx];
    pair_v  = '0;
    win_v   = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      pair_v[c*CONV_BIT +: CONV_BIT] = max_f(even_q[c*CONV_BIT +: CONV_BIT],
                                             act_f(din[c*CONV_BIT +: CONV_BIT]));
      win_v[c*CONV_BIT +: CONV_BIT]  = max_f(lb_rd[c*CONV_BIT +: CONV_BIT],
                                             pair_v[c*CONV_BIT +: CONV_BIT]);
    end
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    even_d  = even_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    lb_we   = 1'b0;
    if (valid_in) begin
      if (!col_eff[0]) begin
        for (int unsigned c = 0; c < CH; c++) begin
          even_d[c*CONV_BIT +: CONV_BIT] = act_f(din[c*CONV_BIT +: CONV_BIT]);
        end
      end else if (!row_eff[0]) begin
        lb_we = 1'b1;
      end else begin
        dout_d  = win_v;
        valid_d = 1'b1;
        done_d  = (row_eff == RW'(IMG_H - 1)) && (col_eff == CW'(IMG_W - 1));
      end
      if (col_eff == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_eff == RW'(IMG_H - 1)) ? '0 : row_eff + RW'(1);
      end else begin
        col_d = col_eff + CW'(1);
        row_d = row_eff;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      even_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      even_q  <= even_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Line buffer is always rewritten on an even row before it is read, so no reset.
  always_ff @(posedge clk) begin
    if (lb_we) lb_q[lb_idx] <= pair_v;
  end

  assign dout       = dout_q;
  assign valid_out  = valid_q;
  assign frame_done = done_q;

endmodule
